// File: rtl/phy_rx_lane_merge.sv
// phy_rx_lane_merge
// Merges four PHY receive lanes into a single registered byte stream.
// Each lane owns a small FIFO; a round-robin arbiter picks which non-empty
// lane feeds the output register. The output register follows a
// valid/ready handshake and holds its contents while stalled.
module phy_rx_lane_merge #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic              valid_in0,
    input  logic              valid_in1,
    input  logic              valid_in2,
    input  logic              valid_in3,
    input  logic              ready_in,
    input  logic              clr_overflow,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [1:0]        lane_out,
    output logic [3:0]        fifo_empty,
    output logic [3:0]        fifo_full,
    output logic [3:0]        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    typedef logic [AW:0] ptr_t;

    logic [DATA_W-1:0] lane_data [4];
    logic [3:0]        lane_valid;

    logic [DATA_W-1:0] mem_q [4][FIFO_DEPTH];
    ptr_t              wr_ptr_q [4];
    ptr_t              wr_ptr_d [4];
    ptr_t              rd_ptr_q [4];
    ptr_t              rd_ptr_d [4];
    logic [3:0]        overflow_q, overflow_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [1:0]        lane_out_q, lane_out_d;
    logic              valid_out_q, valid_out_d;
    logic [1:0]        last_grant_q, last_grant_d;

    logic [1:0]        grant;
    logic              any_ready;
    logic              load;
    logic [3:0]        push;
    logic [3:0]        pop;

    assign lane_data[0] = data_in0;
    assign lane_data[1] = data_in1;
    assign lane_data[2] = data_in2;
    assign lane_data[3] = data_in3;
    assign lane_valid   = {valid_in3, valid_in2, valid_in1, valid_in0};

    assign data_out  = data_out_q;
    assign lane_out  = lane_out_q;
    assign valid_out = valid_out_q;
    assign overflow  = overflow_q;

    // Per-lane status decoded from the registered pointers only.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fifo_empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            fifo_full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                            (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
        end
    end

    // Round-robin search over non-empty lanes, starting after the last grant.
    always_comb begin
        logic [1:0] cand;
        // NOTE: every variable gets a default before any conditional write,
        // otherwise the tool infers a latch to hold the old value.
        cand      = last_grant_q;
        grant     = last_grant_q;
        any_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant_q + 2'(k);
            if (!any_ready && !fifo_empty[cand]) begin
                any_ready = 1'b1;
                grant     = cand;
            end
        end
    end

    // The output register refills when it is free or being drained this cycle.
    assign load = (!valid_out_q || ready_in) && any_ready;

    // Next-state: pops, pushes (a full lane still accepts when it is popped),
    // sticky overflow with set priority, and the output register.
    always_comb begin
        overflow_d   = clr_overflow ? 4'b0000 : overflow_q;
        data_out_d   = data_out_q;
        lane_out_d   = lane_out_q;
        valid_out_d  = valid_out_q;
        last_grant_d = last_grant_q;
        for (int i = 0; i < 4; i++) begin
            pop[i]      = load && (grant == 2'(i));
            push[i]     = lane_valid[i] && (!fifo_full[i] || pop[i]);
            wr_ptr_d[i] = wr_ptr_q[i] + ptr_t'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + ptr_t'(pop[i]);
            if (lane_valid[i] && fifo_full[i] && !pop[i]) begin
                overflow_d[i] = 1'b1;
            end
        end
        if (load) begin
            data_out_d   = mem_q[grant][rd_ptr_q[grant][AW-1:0]];
            lane_out_d   = grant;
            valid_out_d  = 1'b1;
            last_grant_d = grant;
        end else if (ready_in) begin
            valid_out_d  = 1'b0;
        end
    end

    // Control state: asynchronously cleared so reset discards everything at once.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples
        // the pre-edge values; blocking here would create ordering races.
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            overflow_q   <= 4'b0000;
            data_out_q   <= '0;
            lane_out_q   <= 2'd0;
            valid_out_q  <= 1'b0;
            last_grant_q <= 2'd3;
        end else begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
            overflow_q   <= overflow_d;
            data_out_q   <= data_out_d;
            lane_out_q   <= lane_out_d;
            valid_out_q  <= valid_out_d;
            last_grant_q <= last_grant_d;
        end
    end

    // FIFO storage writes. A full lane being popped overwrites the slot that
    // is read out on this same edge, which is safe because the read is pre-edge.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; pointer reset alone makes old contents
        // unreachable, and leaving it out lets the array map to plain RAM.
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= lane_data[i];
            end
        end
    end

endmodule

// File: tb/tb_phy_rx_lane_merge.sv
// Testbench for phy_rx_lane_merge: a vector table for arbitration and single
// lane latency, hand sequences for stall/overflow/full-with-pop/mid-stream
// reset, and a randomized run checked against a queue-based reference model.
module tb_phy_rx_lane_merge;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic [DW-1:0] data_in0, data_in1, data_in2, data_in3;
    logic          valid_in0, valid_in1, valid_in2, valid_in3;
    logic          ready_in;
    logic          clr_overflow;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [1:0]    lane_out;
    logic [3:0]    fifo_empty;
    logic [3:0]    fifo_full;
    logic [3:0]    overflow;

    phy_rx_lane_merge #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in0     (data_in0),
        .data_in1     (data_in1),
        .data_in2     (data_in2),
        .data_in3     (data_in3),
        .valid_in0    (valid_in0),
        .valid_in1    (valid_in1),
        .valid_in2    (valid_in2),
        .valid_in3    (valid_in3),
        .ready_in     (ready_in),
        .clr_overflow (clr_overflow),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .lane_out     (lane_out),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: one queue per lane plus the output holding register.
    logic [7:0] mq [4][$];
    logic       m_valid;
    logic [7:0] m_data;
    int         m_lane;
    int         m_last;
    logic [3:0] m_ovf;

    typedef struct {
        logic [3:0]  vin;
        logic [31:0] din;
        logic        rdy;
        logic        ev;
        logic [7:0]  ed;
        logic [1:0]  el;
        logic [3:0]  ee;
        logic [3:0]  ef;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_lane  = 0;
        m_last  = 3;
        m_ovf   = 4'b0000;
    endtask

    // One cycle of the behavioural rules, applied to the pre-edge state.
    task automatic model_step(input logic [3:0] vin, input logic [31:0] din,
                              input logic rdy, input logic clr);
        int   sz [4];
        bit   popped [4];
        bit   any;
        bit   found;
        int   g;
        any = 0;
        for (int i = 0; i < 4; i++) begin
            sz[i]     = mq[i].size();
            popped[i] = 0;
            if (sz[i] > 0) any = 1;
        end
        if ((!m_valid || rdy) && any) begin
            found = 0;
            g     = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && sz[(m_last + k) % 4] > 0) begin
                    found = 1;
                    g     = (m_last + k) % 4;
                end
            end
            m_data    = mq[g].pop_front();
            m_lane    = g;
            m_valid   = 1'b1;
            m_last    = g;
            popped[g] = 1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        if (clr) m_ovf = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (vin[i]) begin
                if (sz[i] < DEPTH || popped[i]) mq[i].push_back(din[8*i +: 8]);
                else m_ovf[i] = 1'b1;
            end
        end
    endtask

    task automatic compare_model();
        logic [3:0] e_empty;
        logic [3:0] e_full;
        for (int i = 0; i < 4; i++) begin
            e_empty[i] = (mq[i].size() == 0);
            e_full[i]  = (mq[i].size() == DEPTH);
        end
        check("model valid_out", {31'd0, valid_out}, {31'd0, m_valid});
        if (m_valid) begin
            check("model data_out", {24'd0, data_out}, {24'd0, m_data});
            check("model lane_out", {30'd0, lane_out}, m_lane);
        end
        check("model fifo_empty", {28'd0, fifo_empty}, {28'd0, e_empty});
        check("model fifo_full", {28'd0, fifo_full}, {28'd0, e_full});
        check("model overflow", {28'd0, overflow}, {28'd0, m_ovf});
    endtask

    // Drive one cycle of stimulus, advance the model, then sample after the edge.
    task automatic cycle(input logic [3:0] vin, input logic [31:0] din,
                         input logic rdy, input logic clr);
        valid_in0    = vin[0];
        valid_in1    = vin[1];
        valid_in2    = vin[2];
        valid_in3    = vin[3];
        data_in0     = din[7:0];
        data_in1     = din[15:8];
        data_in2     = din[23:16];
        data_in3     = din[31:24];
        ready_in     = rdy;
        clr_overflow = clr;
        model_step(vin, din, rdy, clr);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        valid_in0 = 0; valid_in1 = 0; valid_in2 = 0; valid_in3 = 0;
        data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;
        ready_in = 0;
        clr_overflow = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " valid_out"}, {31'd0, valid_out}, 32'd0);
        check({tag, " data_out"}, {24'd0, data_out}, 32'd0);
        check({tag, " lane_out"}, {30'd0, lane_out}, 32'd0);
        check({tag, " fifo_empty"}, {28'd0, fifo_empty}, 32'hF);
        check({tag, " fifo_full"}, {28'd0, fifo_full}, 32'h0);
        check({tag, " overflow"}, {28'd0, overflow}, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();

        // Fairness from reset (lane 0 first), then a lone lane-2 byte.
        vecs[0] = '{4'b1111, 32'h13121110, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000, 4'b0000};
        vecs[1] = '{4'b0000, 32'h00000000, 1'b1, 1'b1, 8'h10, 2'd0, 4'b0001, 4'b0000};
        vecs[2] = '{4'b0000, 32'h00000000, 1'b1, 1'b1, 8'h11, 2'd1, 4'b0011, 4'b0000};
        vecs[3] = '{4'b0000, 32'h00000000, 1'b1, 1'b1, 8'h12, 2'd2, 4'b0111, 4'b0000};
        vecs[4] = '{4'b0000, 32'h00000000, 1'b1, 1'b1, 8'h13, 2'd3, 4'b1111, 4'b0000};
        vecs[5] = '{4'b0000, 32'h00000000, 1'b1, 1'b0, 8'h00, 2'd0, 4'b1111, 4'b0000};
        vecs[6] = '{4'b0100, 32'h00A50000, 1'b1, 1'b0, 8'h00, 2'd0, 4'b1011, 4'b0000};
        vecs[7] = '{4'b0000, 32'h00000000, 1'b1, 1'b1, 8'hA5, 2'd2, 4'b1111, 4'b0000};
        vecs[8] = '{4'b0000, 32'h00000000, 1'b1, 1'b0, 8'h00, 2'd0, 4'b1111, 4'b0000};

        do_reset();
        for (int r = 0; r < 9; r++) begin
            cycle(vecs[r].vin, vecs[r].din, vecs[r].rdy, 1'b0);
            check($sformatf("vec%0d valid_out", r), {31'd0, valid_out}, {31'd0, vecs[r].ev});
            if (vecs[r].ev) begin
                check($sformatf("vec%0d data_out", r), {24'd0, data_out}, {24'd0, vecs[r].ed});
                check($sformatf("vec%0d lane_out", r), {30'd0, lane_out}, {30'd0, vecs[r].el});
            end
            check($sformatf("vec%0d fifo_empty", r), {28'd0, fifo_empty}, {28'd0, vecs[r].ee});
            check($sformatf("vec%0d fifo_full", r), {28'd0, fifo_full}, {28'd0, vecs[r].ef});
        end

        // Backpressure: lane 0 pushes 01..05 while stalled.
        do_reset();
        for (int k = 1; k <= 5; k++) cycle(4'b0001, 32'(k), 1'b0, 1'b0);
        check("stall data_out", {24'd0, data_out}, 32'h01);
        check("stall valid_out", {31'd0, valid_out}, 32'd1);
        check("stall fifo_full", {28'd0, fifo_full}, 32'h1);
        check("stall overflow", {28'd0, overflow}, 32'h0);
        // Sixth push while full and stalled is dropped.
        cycle(4'b0001, 32'h06, 1'b0, 1'b0);
        check("drop overflow", {28'd0, overflow}, 32'h1);
        cycle(4'b0000, 32'h0, 1'b0, 1'b1);
        check("clr overflow", {28'd0, overflow}, 32'h0);
        // Clear and a new drop on the same edge: set wins.
        cycle(4'b0001, 32'h07, 1'b0, 1'b1);
        check("set wins overflow", {28'd0, overflow}, 32'h1);
        cycle(4'b0000, 32'h0, 1'b0, 1'b1);
        check("clr again overflow", {28'd0, overflow}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cycle(4'b0000, 32'h0, 1'b1, 1'b0);
            check($sformatf("drain%0d data_out", k), {24'd0, data_out}, 32'(k + 2));
        end
        cycle(4'b0000, 32'h0, 1'b1, 1'b0);
        check("drain end valid_out", {31'd0, valid_out}, 32'd0);

        // Full lane 1 accepts a push in the same cycle as a pop.
        do_reset();
        for (int k = 0; k < 5; k++) cycle(4'b0010, 32'(8'h20 + k) << 8, 1'b0, 1'b0);
        check("l1 full", {28'd0, fifo_full}, 32'h2);
        cycle(4'b0010, 32'h00007700, 1'b1, 1'b0);
        check("pushpop data_out", {24'd0, data_out}, 32'h21);
        check("pushpop fifo_full", {28'd0, fifo_full}, 32'h2);
        check("pushpop overflow", {28'd0, overflow}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cycle(4'b0000, 32'h0, 1'b1, 1'b0);
            check($sformatf("pushpop out%0d", k), {24'd0, data_out},
                  (k == 3) ? 32'h77 : 32'(8'h22 + k));
        end
        cycle(4'b0000, 32'h0, 1'b1, 1'b0);
        check("pushpop end valid_out", {31'd0, valid_out}, 32'd0);

        // Mid-stream reset clears state between clock edges.
        do_reset();
        cycle(4'b0111, 32'h00424140, 1'b0, 1'b0);
        cycle(4'b0000, 32'h0, 1'b0, 1'b0);
        check("pre-reset valid_out", {31'd0, valid_out}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async reset");
        idle_inputs();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle(4'b1000, 32'h3C000000, 1'b1, 1'b0);
        check("post-reset edge1 valid_out", {31'd0, valid_out}, 32'd0);
        cycle(4'b0000, 32'h0, 1'b1, 1'b0);
        check("post-reset edge2 valid_out", {31'd0, valid_out}, 32'd1);
        check("post-reset edge2 data_out", {24'd0, data_out}, 32'h3C);
        check("post-reset edge2 lane_out", {30'd0, lane_out}, 32'd3);

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [3:0]  rvin;
            logic [31:0] rdin;
            logic        rrdy;
            logic        rclr;
            rvin = 4'($urandom_range(0, 15));
            rdin = $urandom;
            rrdy = ($urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 7 : 3));
            rclr = ($urandom_range(0, 15) == 0);
            cycle(rvin, rdin, rrdy, rclr);
        end

        idle_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
